// File: rtl/line_fill_buffer_pkg.sv
// ----------------------------------------------------------------------------
// lb_pkg : shared definitions for the line fill buffer.
//   - lb_state_e : fill controller states
//   - AXI encodings used on the read address / read data channels
//   - off_w()    : word-offset width for a given line size
// No ports (package).
// ----------------------------------------------------------------------------
package lb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } lb_state_e;

    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Number of address bits selecting a 32-bit word inside a line.
    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

endpackage

// File: rtl/line_fill_buffer_if.sv
// ----------------------------------------------------------------------------
// line_fill_buffer_if : AXI4 read-only channel bundle between the line fill
// buffer (master) and the interconnect (slave).
//   AR: M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID / M_ARREADY
//   R : M_RDATA, M_RRESP, M_RLAST, M_RVALID / M_RREADY
// ----------------------------------------------------------------------------
interface line_fill_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] M_ARADDR;
    logic [7:0]        M_ARLEN;
    logic [2:0]        M_ARSIZE;
    logic [1:0]        M_ARBURST;
    logic              M_ARVALID;
    logic              M_ARREADY;
    logic [DATA_W-1:0] M_RDATA;
    logic [1:0]        M_RRESP;
    logic              M_RLAST;
    logic              M_RVALID;
    logic              M_RREADY;

    modport master (
        output M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID,
        input  M_ARREADY,
        input  M_RDATA, M_RRESP, M_RLAST, M_RVALID,
        output M_RREADY
    );

    modport slave (
        input  M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARVALID,
        output M_ARREADY,
        output M_RDATA, M_RRESP, M_RLAST, M_RVALID,
        input  M_RREADY
    );
endinterface

// File: rtl/line_fill_buffer_word_store.sv
// ----------------------------------------------------------------------------
// lb_word_store : line register array with a per-word valid mask.
// Ports:
//   Clk, Rst   clock, asynchronous active-low reset (clears data and mask)
//   clear_i    clears the valid mask only; word contents are kept
//   we_i       write enable for word idx_i with data_i (sets its valid bit)
//   line_o     flattened line, word i at [i*DATA_W +: DATA_W]
//   valid_o    per-word valid mask
// ----------------------------------------------------------------------------
module lb_word_store #(
    parameter int WORDS  = 8,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 3
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    clear_i,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        idx_i,
    input  logic [DATA_W-1:0]       data_i,
    output logic [WORDS*DATA_W-1:0] line_o,
    output logic [WORDS-1:0]        valid_o
);

    logic [DATA_W-1:0] words_q [WORDS];
    logic [WORDS-1:0]  valid_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < WORDS; i++) begin
                words_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            if (clear_i) begin
                valid_q <= '0;
            end else if (we_i) begin
                valid_q[idx_i] <= 1'b1;
            end
            if (we_i) begin
                words_q[idx_i] <= data_i;
            end
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_flat
        assign line_o[g*DATA_W +: DATA_W] = words_q[g];
    end

    assign valid_o = valid_q;

endmodule

// File: rtl/line_fill_buffer.sv
// ----------------------------------------------------------------------------
// line_fill_buffer : fetches one cache line over an AXI4 WRAP read burst,
// critical word first.
// Ports:
//   Clk, Rst        clock, asynchronous active-low reset
//   LB_Enable       fill request / hold from cache control
//   WordAddress     byte address of the missing word (sampled at fill start)
//   LineAddress     line-aligned address of the current / last fill
//   LB_FirstWord    one-cycle pulse when the critical word has arrived
//   CrtWord_Data    critical word, held until the next critical word
//   LB_Completed    level, all words received (held while LB_Enable=1)
//   Line_Data       assembled line, word i at [i*32 +: 32]
//   Fill_Error      sticky: bad RRESP or RLAST misplaced; cleared at fill start
//   axi             AXI4 read master (line_fill_buffer_if.master)
// Optional build macro LB_FORWARD_EN adds Fwd_Addr / Fwd_Hit / Fwd_Data for
// hit-under-fill on words already received.
//
// state | meaning
// IDLE  | waiting for LB_Enable
// ADDR  | ARVALID high until ARREADY
// DATA  | RREADY high, collecting WORDS_PER_LINE beats
// DONE  | line complete, held until LB_Enable drops
// ----------------------------------------------------------------------------
module line_fill_buffer
    import lb_pkg::*;
#(
    parameter int WORDS_PER_LINE = 8,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic                             LB_Enable,
    input  logic [ADDR_W-1:0]                WordAddress,
    output logic [ADDR_W-1:0]                LineAddress,
    output logic                             LB_FirstWord,
    output logic [DATA_W-1:0]                CrtWord_Data,
    output logic                             LB_Completed,
    output logic [WORDS_PER_LINE*DATA_W-1:0] Line_Data,
    output logic                             Fill_Error,
`ifdef LB_FORWARD_EN
    input  logic [ADDR_W-1:0]                Fwd_Addr,
    output logic                             Fwd_Hit,
    output logic [DATA_W-1:0]                Fwd_Data,
`endif
    line_fill_buffer_if.master               axi
);

    localparam int OFF_W = off_w(WORDS_PER_LINE);
    localparam int LAST  = WORDS_PER_LINE - 1;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(WORDS_PER_LINE*4 - 1);

    lb_state_e         state_q;
    logic [ADDR_W-1:0] line_addr_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [OFF_W-1:0]  start_idx_q;
    logic [OFF_W-1:0]  beat_cnt_q;
    logic              first_word_q;
    logic [DATA_W-1:0] crt_word_q;
    logic              fill_err_q;
    logic              arvalid_q;
    logic              rready_q;
    logic              completed_q;

    logic                      beat_fire;
    logic                      last_beat;
    logic                      fill_start;
    logic [OFF_W-1:0]          wr_idx;
    logic [WORDS_PER_LINE-1:0] valid_mask;

    // rready_q is only ever high in DATA, so it doubles as the state qualifier.
    assign beat_fire  = rready_q & axi.M_RVALID;
    assign last_beat  = (beat_cnt_q == OFF_W'(LAST));
    assign fill_start = (state_q == ST_IDLE) & LB_Enable;
    // OFF_W-bit sum wraps around the line exactly like the WRAP burst does.
    assign wr_idx     = start_idx_q + beat_cnt_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= ST_IDLE;
            line_addr_q  <= '0;
            araddr_q     <= '0;
            start_idx_q  <= '0;
            beat_cnt_q   <= '0;
            first_word_q <= 1'b0;
            crt_word_q   <= '0;
            fill_err_q   <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            completed_q  <= 1'b0;
        end else begin
            first_word_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (LB_Enable) begin
                        state_q     <= ST_ADDR;
                        line_addr_q <= WordAddress & LINE_MASK;
                        araddr_q    <= WordAddress & WORD_MASK;
                        start_idx_q <= WordAddress[OFF_W+1:2];
                        beat_cnt_q  <= '0;
                        fill_err_q  <= 1'b0;
                        arvalid_q   <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (axi.M_ARREADY) begin
                        state_q   <= ST_DATA;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (beat_fire) begin
                        beat_cnt_q <= beat_cnt_q + OFF_W'(1);
                        if (beat_cnt_q == '0) begin
                            first_word_q <= 1'b1;
                            crt_word_q   <= axi.M_RDATA;
                        end
                        if (axi.M_RRESP != RESP_OKAY) begin
                            fill_err_q <= 1'b1;
                        end
                        // Completion is decided by the beat count; RLAST only
                        // feeds the error flag.
                        if (last_beat) begin
                            if (!axi.M_RLAST) begin
                                fill_err_q <= 1'b1;
                            end
                            state_q     <= ST_DONE;
                            rready_q    <= 1'b0;
                            completed_q <= 1'b1;
                        end else if (axi.M_RLAST) begin
                            fill_err_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!LB_Enable) begin
                        state_q     <= ST_IDLE;
                        completed_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    lb_word_store #(
        .WORDS  (WORDS_PER_LINE),
        .DATA_W (DATA_W),
        .IDX_W  (OFF_W)
    ) u_store (
        .Clk     (Clk),
        .Rst     (Rst),
        .clear_i (fill_start),
        .we_i    (beat_fire),
        .idx_i   (wr_idx),
        .data_i  (axi.M_RDATA),
        .line_o  (Line_Data),
        .valid_o (valid_mask)
    );

    // Burst attributes are only driven while the request is presented.
    assign axi.M_ARVALID = arvalid_q;
    assign axi.M_ARADDR  = arvalid_q ? araddr_q : '0;
    assign axi.M_ARLEN   = arvalid_q ? 8'(LAST) : 8'd0;
    assign axi.M_ARSIZE  = arvalid_q ? SIZE_4B : 3'b000;
    assign axi.M_ARBURST = arvalid_q ? BURST_WRAP : 2'b00;
    assign axi.M_RREADY  = rready_q;

    assign LineAddress  = line_addr_q;
    assign LB_FirstWord = first_word_q;
    assign CrtWord_Data = crt_word_q;
    assign LB_Completed = completed_q;
    assign Fill_Error   = fill_err_q;

`ifdef LB_FORWARD_EN
    logic [OFF_W-1:0] fwd_idx;
    logic             fwd_line_match;
    logic             unused_fwd;

    assign fwd_idx        = Fwd_Addr[OFF_W+1:2];
    assign fwd_line_match = (Fwd_Addr[ADDR_W-1:OFF_W+2] == line_addr_q[ADDR_W-1:OFF_W+2]);
    assign Fwd_Hit        = ((state_q == ST_DATA) || (state_q == ST_DONE))
                            && fwd_line_match && valid_mask[fwd_idx];
    assign Fwd_Data       = Line_Data[fwd_idx*DATA_W +: DATA_W];
    assign unused_fwd     = ^Fwd_Addr[1:0];
`else
    // The valid mask only feeds the forwarding comparator.
    logic unused_valid;
    assign unused_valid = ^valid_mask;
`endif

endmodule

// File: tb/tb_line_fill_buffer.sv
module tb_line_fill_buffer;
    logic         Clk;
    logic         Rst;
    logic         LB_Enable;
    logic [31:0]  WordAddress;
    logic [31:0]  LineAddress;
    logic         LB_FirstWord;
    logic [31:0]  CrtWord_Data;
    logic         LB_Completed;
    logic [255:0] Line_Data;
    logic         Fill_Error;
`ifdef LB_FORWARD_EN
    logic [31:0]  Fwd_Addr;
    logic         Fwd_Hit;
    logic [31:0]  Fwd_Data;
`endif

    line_fill_buffer_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    line_fill_buffer #(.WORDS_PER_LINE(8), .ADDR_W(32), .DATA_W(32)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .LB_Enable    (LB_Enable),
        .WordAddress  (WordAddress),
        .LineAddress  (LineAddress),
        .LB_FirstWord (LB_FirstWord),
        .CrtWord_Data (CrtWord_Data),
        .LB_Completed (LB_Completed),
        .Line_Data    (Line_Data),
        .Fill_Error   (Fill_Error),
`ifdef LB_FORWARD_EN
        .Fwd_Addr     (Fwd_Addr),
        .Fwd_Hit      (Fwd_Hit),
        .Fwd_Data     (Fwd_Data),
`endif
        .axi          (axi)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] addr;
        int          ar_delay;
        logic [7:0]  gaps;       // bit k: one idle cycle before beat k
        int          err_beat;   // beat with RRESP=SLVERR, 8 = none
        int          rlast_beat; // beat carrying RLAST
        int          hold;       // extra DONE cycles with LB_Enable high
        int          drop_beat;  // LB_Enable dropped before this beat, -1 = never
        logic [31:0] base;       // beat k carries base+k
        logic [31:0] exp_line;
        logic [31:0] exp_araddr;
        logic [31:0] exp_w0;
        logic [31:0] exp_w7;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic run_fill(input vec_t v, input int vi);
        int s;
        s = int'(v.addr[4:2]);
        @(negedge Clk);
        WordAddress = v.addr;
        LB_Enable   = 1'b1;
        @(negedge Clk);
        check($sformatf("v%0d arvalid", vi), 64'(axi.M_ARVALID), 64'd1);
        check($sformatf("v%0d araddr", vi), 64'(axi.M_ARADDR), 64'(v.exp_araddr));
        check($sformatf("v%0d arlen", vi), 64'(axi.M_ARLEN), 64'd7);
        check($sformatf("v%0d arsize", vi), 64'(axi.M_ARSIZE), 64'd2);
        check($sformatf("v%0d arburst", vi), 64'(axi.M_ARBURST), 64'd2);
        check($sformatf("v%0d line_addr", vi), 64'(LineAddress), 64'(v.exp_line));
        check($sformatf("v%0d err_cleared", vi), 64'(Fill_Error), 64'd0);
        WordAddress = 32'hDEAD_BEE0;
        for (int d = 0; d < v.ar_delay; d++) begin
            @(negedge Clk);
            check($sformatf("v%0d arvalid_hold", vi), 64'(axi.M_ARVALID), 64'd1);
            check($sformatf("v%0d araddr_hold", vi), 64'(axi.M_ARADDR), 64'(v.exp_araddr));
        end
        axi.M_ARREADY = 1'b1;
        @(negedge Clk);
        axi.M_ARREADY = 1'b0;
        check($sformatf("v%0d arvalid_drop", vi), 64'(axi.M_ARVALID), 64'd0);
        check($sformatf("v%0d rready", vi), 64'(axi.M_RREADY), 64'd1);
        for (int k = 0; k < 8; k++) begin
            if (v.gaps[k]) begin
                @(negedge Clk);
                check($sformatf("v%0d gap_no_done", vi), 64'(LB_Completed), 64'd0);
            end
            if (k == v.drop_beat) LB_Enable = 1'b0;
`ifdef LB_FORWARD_EN
            if (vi == 0 && k == 5) begin
                Fwd_Addr = 32'h0000_1008;
                #1 check("fwd_before", 64'(Fwd_Hit), 64'd0);
            end
`endif
            axi.M_RVALID = 1'b1;
            axi.M_RDATA  = v.base + 32'(k);
            axi.M_RRESP  = (k == v.err_beat) ? 2'b10 : 2'b00;
            axi.M_RLAST  = (k == v.rlast_beat);
            @(negedge Clk);
            axi.M_RVALID = 1'b0;
            axi.M_RLAST  = 1'b0;
            axi.M_RRESP  = 2'b00;
            axi.M_RDATA  = 32'h0;
            if (k == 0) begin
                check($sformatf("v%0d first_word", vi), 64'(LB_FirstWord), 64'd1);
                check($sformatf("v%0d crt_word", vi), 64'(CrtWord_Data), 64'(v.base));
            end else if (k == 1) begin
                check($sformatf("v%0d first_word_pulse", vi), 64'(LB_FirstWord), 64'd0);
            end
            if (k < 7) check($sformatf("v%0d early_done", vi), 64'(LB_Completed), 64'd0);
`ifdef LB_FORWARD_EN
            if (vi == 0 && k == 5) begin
                #1 check("fwd_hit", 64'(Fwd_Hit), 64'd1);
                check("fwd_data", 64'(Fwd_Data), 64'(v.base + 32'd5));
                Fwd_Addr = 32'h0000_2008;
                #1 check("fwd_other_line", 64'(Fwd_Hit), 64'd0);
                Fwd_Addr = 32'h0;
            end
`endif
        end
        check($sformatf("v%0d completed", vi), 64'(LB_Completed), 64'd1);
        check($sformatf("v%0d rready_off", vi), 64'(axi.M_RREADY), 64'd0);
        check($sformatf("v%0d fill_error", vi), 64'(Fill_Error), 64'(v.exp_err));
        check($sformatf("v%0d word0", vi), 64'(Line_Data[31:0]), 64'(v.exp_w0));
        check($sformatf("v%0d word7", vi), 64'(Line_Data[255:224]), 64'(v.exp_w7));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("v%0d word%0d", vi, i), 64'(Line_Data[i*32 +: 32]),
                  64'(v.base + 32'((i - s) & 7)));
        end
        for (int h = 0; h < v.hold; h++) begin
            @(negedge Clk);
            check($sformatf("v%0d completed_hold", vi), 64'(LB_Completed), 64'd1);
        end
        LB_Enable = 1'b0;
        @(negedge Clk);
        check($sformatf("v%0d completed_drop", vi), 64'(LB_Completed), 64'd0);
        check($sformatf("v%0d idle_arvalid", vi), 64'(axi.M_ARVALID), 64'd0);
        check($sformatf("v%0d line_persist", vi), 64'(LineAddress), 64'(v.exp_line));
        check($sformatf("v%0d crt_persist", vi), 64'(CrtWord_Data), 64'(v.base));
    endtask

    initial begin
        //           addr          ard gaps          err rl hold drop base           line          araddr        w0             w7             err
        vecs[0] = '{32'h0000_1014, 2, 8'b0000_0000, 8, 7, 0, -1, 32'hA000_0000, 32'h0000_1000, 32'h0000_1014, 32'hA000_0003, 32'hA000_0002, 1'b0};
        vecs[1] = '{32'h0000_201C, 0, 8'b0000_1010, 8, 7, 0, -1, 32'hB000_0000, 32'h0000_2000, 32'h0000_201C, 32'hB000_0001, 32'hB000_0000, 1'b0};
        vecs[2] = '{32'h0000_3008, 1, 8'b0101_0010, 8, 7, 5, -1, 32'hC000_0000, 32'h0000_3000, 32'h0000_3008, 32'hC000_0006, 32'hC000_0005, 1'b0};
        vecs[3] = '{32'h0000_4000, 0, 8'b0000_0000, 3, 7, 0, -1, 32'hD000_0000, 32'h0000_4000, 32'h0000_4000, 32'hD000_0000, 32'hD000_0007, 1'b1};
        vecs[4] = '{32'h0000_5012, 0, 8'b0000_0000, 8, 6, 0, -1, 32'hE000_0000, 32'h0000_5000, 32'h0000_5010, 32'hE000_0004, 32'hE000_0003, 1'b1};
        vecs[5] = '{32'h0000_6004, 1, 8'b0000_1000, 8, 7, 0,  3, 32'h1100_0000, 32'h0000_6000, 32'h0000_6004, 32'h1100_0007, 32'h1100_0006, 1'b0};
        vecs[6] = '{32'h0000_7010, 1, 8'b0000_0000, 8, 7, 2, -1, 32'h2200_0000, 32'h0000_7000, 32'h0000_7010, 32'h2200_0004, 32'h2200_0003, 1'b0};

        Rst           = 1'b0;
        LB_Enable     = 1'b0;
        WordAddress   = 32'h0;
        axi.M_ARREADY = 1'b0;
        axi.M_RVALID  = 1'b0;
        axi.M_RDATA   = 32'h0;
        axi.M_RRESP   = 2'b00;
        axi.M_RLAST   = 1'b0;
`ifdef LB_FORWARD_EN
        Fwd_Addr      = 32'h0;
`endif
        #22;
        check("rst_completed", 64'(LB_Completed), 64'd0);
        check("rst_arvalid", 64'(axi.M_ARVALID), 64'd0);
        check("rst_line_zero", 64'(Line_Data == '0), 64'd1);
        @(negedge Clk);
        Rst = 1'b1;

        for (int i = 0; i < 6; i++) run_fill(vecs[i], i);

        // Asynchronous reset in the middle of the data phase.
        @(negedge Clk);
        WordAddress = 32'h0000_7010;
        LB_Enable   = 1'b1;
        @(negedge Clk);
        axi.M_ARREADY = 1'b1;
        @(negedge Clk);
        axi.M_ARREADY = 1'b0;
        for (int k = 0; k < 4; k++) begin
            axi.M_RVALID = 1'b1;
            axi.M_RDATA  = 32'h5500_0000 + 32'(k);
            @(negedge Clk);
        end
        axi.M_RVALID = 1'b0;
        check("pre_rst_line_nonzero", 64'(Line_Data != '0), 64'd1);
        #2 Rst = 1'b0;
        #1;
        check("arst_line_data", 64'(Line_Data == '0), 64'd1);
        check("arst_line_addr", 64'(LineAddress), 64'd0);
        check("arst_crt_word", 64'(CrtWord_Data), 64'd0);
        check("arst_rready", 64'(axi.M_RREADY), 64'd0);
        check("arst_arvalid", 64'(axi.M_ARVALID), 64'd0);
        check("arst_first_word", 64'(LB_FirstWord), 64'd0);
        check("arst_fill_error", 64'(Fill_Error), 64'd0);
        LB_Enable = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        check("post_rst_idle", 64'(axi.M_ARVALID), 64'd0);
        run_fill(vecs[6], 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end
endmodule

// File: doc/line_fill_buffer.md
Name: line_fill_buffer

Overview:
- Fetches one cache line from memory over an AXI4 read burst whenever the cache controller raises LB_Enable.
- Returns the critical (requested) word first, flagging it with LB_FirstWord, and flags the full line with LB_Completed.
- Sits between the instruction/data cache controller and the AXI interconnect.
- Holds the assembled line for the controller's line-write cycle into the cache array.

Parameters:
- WORDS_PER_LINE, 8: words per line; power of two, 2..16. Offset width OFF_W = log2(WORDS_PER_LINE) (3 at default, address bits [4:2]).
- ADDR_W, 32: byte address width.
- DATA_W, 32: word and AXI data width; fixed at 32.

Ports:
- Clk in 1: single clock.
- Rst in 1: asynchronous active-low reset.
- LB_Enable in 1: fill request/hold from cache control.
- WordAddress in ADDR_W: byte address of the missing word; sampled at fill start.
- LineAddress out ADDR_W: latched line-aligned address of the fill in progress or just completed.
- LB_FirstWord out 1: one-cycle pulse when the critical word is accepted.
- CrtWord_Data out DATA_W: critical word; valid when LB_FirstWord=1 and held until the next fill.
- LB_Completed out 1: level; all words received.
- Line_Data out WORDS_PER_LINE*DATA_W: assembled line; word i at bits [i*32+:32].
- Fill_Error out 1: sticky error flag; cleared at the next fill start.
- M_ARADDR out ADDR_W, M_ARLEN out 8, M_ARSIZE out 3, M_ARBURST out 2, M_ARVALID out 1, M_ARREADY in 1: AXI read address channel.
- M_RDATA in DATA_W, M_RRESP in 2, M_RLAST in 1, M_RVALID in 1, M_RREADY out 1: AXI read data channel.

Behaviour:
- Reset (Rst=0, asynchronous) forces:
  - state IDLE; all outputs 0, including Line_Data, CrtWord_Data, LineAddress and the valid mask.
  - An outstanding AXI burst is abandoned; the interconnect is reset on the same net.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: on LB_Enable=1, go to ADDR next cycle.
  - Latch LineAddress = WordAddress with offset and byte bits zeroed.
  - Latch start index S = WordAddress[OFF_W+1:2].
  - Clear Fill_Error and the valid mask.
- ADDR:
  - M_ARVALID=1.
  - M_ARADDR = WordAddress word-aligned (critical word first).
  - M_ARLEN = WORDS_PER_LINE-1; M_ARSIZE = 3'b010; M_ARBURST = 2'b10 (WRAP).
  - Held stable until M_ARREADY=1, then go to DATA. ARVALID never drops before the handshake.
- DATA: M_RREADY=1. On each beat (RVALID & RREADY):
  - Store RDATA at index (S + beat_cnt) mod WORDS_PER_LINE; the OFF_W-bit adder wraps naturally.
  - Set that word's valid bit; increment beat_cnt.
  - Beat 0 drives LB_FirstWord=1 for exactly the next cycle and loads CrtWord_Data.
  - RRESP != OKAY on any beat sets Fill_Error; the data is still stored and the fill continues.
  - Last beat (beat_cnt == WORDS_PER_LINE-1): go to DONE. If RLAST=0 here, or RLAST=1 on an earlier beat, set Fill_Error. The count alone decides completion.
- DONE:
  - LB_Completed=1, held while LB_Enable=1.
  - When LB_Enable=0, go to IDLE; LB_Completed drops that cycle.
  - Line_Data and LineAddress persist until the next fill start.
- LB_Enable dropping in ADDR or DATA is ignored; the burst must finish (AXI forbids abandoning it). DONE then exits immediately because LB_Enable is already 0.
- Gaps: RVALID gaps stall beat_cnt only; there are no timeouts.
- Latency:
  - LB_Enable to ARVALID: 1 cycle.
  - First RVALID beat to LB_FirstWord: 1 cycle.
  - Last beat to LB_Completed: 1 cycle.
- WORDS_PER_LINE=2 edge case: LB_FirstWord and the transition to DONE are one beat apart; LB_FirstWord and LB_Completed are never high in the same cycle.

Optional Feature:
- Macro: LB_FORWARD_EN.
- Defined: adds ports Fwd_Addr in ADDR_W, Fwd_Hit out 1, Fwd_Data out DATA_W.
  - Fwd_Hit is combinational: state is DATA or DONE, AND Fwd_Addr line bits match LineAddress, AND the addressed word's valid bit is set.
  - Fwd_Data is the matching Line_Data word.
  - Allows hit-under-fill for words already received.
- Undefined: these ports are absent and no comparator is built.

Decomposition:
- Shared package lb_pkg holds:
  - FSM state enum.
  - AXI constants: BURST_WRAP=2'b10, SIZE_4B=3'b010, RESP_OKAY=2'b00.
  - Function for the OFF_W calculation.
- One sub-module, lb_word_store:
  - Line register array plus per-word valid mask.
  - Write port (index, data, we); clear input.
  - Outputs: flattened Line_Data and valid mask.

Test Plan:
- WordAddress=0x0000_1014, ARREADY after 2 cycles, 8 back-to-back beats D0..D7 -> ARADDR=0x1014, ARLEN=7, ARBURST=2; LineAddress=0x1000; LB_FirstWord pulses 1 cycle with CrtWord_Data=D0; words 5,6,7,0..4 hold D0..D7; LB_Completed after beat 8.
- WordAddress=0x0000_201C (index 7) -> beat 1 is stored at index 0, showing wrap-around; Line_Data word 7 = first beat.
- RVALID with random gaps, LB_Enable held high through DONE for 5 cycles -> LB_Completed stays 1 for those 5 cycles; IDLE one cycle after LB_Enable=0.
- RRESP=2'b10 on beat 3, and separately RLAST asserted on beat 6 -> Fill_Error=1, still 8 beats stored, Fill_Error cleared at next LB_Enable.
- Rst asserted low mid-DATA after 4 beats -> all outputs 0 immediately (asynchronous); a new fill after release starts at ADDR cleanly.
- With LB_FORWARD_EN defined, Fwd_Addr = line+word 2 before/after its beat -> Fwd_Hit 0 then 1 with correct Fwd_Data; a different line gives Fwd_Hit=0.
